// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result packer slice:
//   - default operand width and result-buffer depth
//   - packer FSM state type and its encodings
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  // Plain vector encodings so the state register stays legacy-compatible.
  typedef logic [1:0] packer_state_t;

  localparam packer_state_t ST_IDLE    = 2'd0;
  localparam packer_state_t ST_SEND_LO = 2'd1;
  localparam packer_state_t ST_SEND_HI = 2'd2;

endpackage : alu_pkg

// File: rtl/alu_result_packer_if.sv
// -----------------------------------------------------------------------------
// alu_result_packer_if
// Bundles the ALU-side input, the beat-stream output and the status flags of
// alu_result_packer.
//   master : upstream/downstream environment (drives ALU_result, ALU_result_valid,
//            out_ready; observes everything else)
//   slave  : the packer itself
// -----------------------------------------------------------------------------
interface alu_result_packer_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [2*DATA_WIDTH-1:0] ALU_result;
  logic                    ALU_result_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    busy;

  modport master (
    output ALU_result, ALU_result_valid, out_ready,
    input  out_data, out_valid, out_last, fifo_full, fifo_empty, busy
  );

  modport slave (
    input  ALU_result, ALU_result_valid, out_ready,
    output out_data, out_valid, out_last, fifo_full, fifo_empty, busy
  );

endinterface : alu_result_packer_if

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
// Synchronous first-word-fall-through FIFO holding whole ALU results.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   i_push, i_wdata    : write request and data (ignored while full)
//   i_pop              : advance read pointer (ignored while empty)
//   o_rdata            : current head entry
//   o_full, o_empty    : registered occupancy flags
// Pointers carry one extra MSB so full and empty are distinguishable when the
// index bits are equal.
// -----------------------------------------------------------------------------
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_wr_ptr_nxt;
  logic [AW:0]      w_rd_ptr_nxt;

  assign w_push       = i_push && !r_full;
  assign w_pop        = i_pop && !r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                  (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, and a reset-free array maps onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule : alu_result_fifo

// File: rtl/alu_result_packer.sv
// -----------------------------------------------------------------------------
// alu_result_packer
// Buffers 2*DATA_WIDTH ALU results and serialises each into two DATA_WIDTH
// beats on a valid/ready stream: lower half first (out_last=0), upper half
// second (out_last=1). Results arriving while the buffer is full are dropped.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus (slave)  : ALU_result/ALU_result_valid in, out_data/out_valid/
//                  out_last out with out_ready in, fifo_full/fifo_empty/busy
//   drop_count   : 8-bit saturating count of dropped results, present only
//                  when ALU_PACKER_DROP_COUNT_EN is defined
// -----------------------------------------------------------------------------
module alu_result_packer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  alu_result_packer_if.slave  bus
`ifdef ALU_PACKER_DROP_COUNT_EN
  ,
  output logic [7:0]          drop_count
`endif
);

  localparam int unsigned RW = 2 * DATA_WIDTH;

  packer_state_t         r_state;
  logic [RW-1:0]         r_hold;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_push;
  logic                  w_pop;
  logic [RW-1:0]         w_fifo_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // A full buffer rejects the word even if a pop frees a slot this same edge.
  assign w_push = bus.ALU_result_valid && !w_fifo_full;

  alu_result_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (bus.ALU_result),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Pop when idle with data waiting, or when the upper beat completes and
  // another result is queued (back-to-back, no bubble).
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE:    w_pop = !w_fifo_empty;
      ST_SEND_HI: w_pop = bus.out_ready && !w_fifo_empty;
      default:    w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_hold      <= w_fifo_rdata;
            r_out_data  <= w_fifo_rdata[DATA_WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (bus.out_ready) begin
            r_out_data <= r_hold[RW-1:DATA_WIDTH];
            r_out_last <= 1'b1;
            r_state    <= ST_SEND_HI;
          end
        end
        ST_SEND_HI: begin
          if (bus.out_ready) begin
            if (!w_fifo_empty) begin
              r_hold     <= w_fifo_rdata;
              r_out_data <= w_fifo_rdata[DATA_WIDTH-1:0];
              r_out_last <= 1'b0;
              r_state    <= ST_SEND_LO;
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.fifo_full  = w_fifo_full;
  assign bus.fifo_empty = w_fifo_empty;
  assign bus.busy       = (r_state != ST_IDLE) || !w_fifo_empty;

`ifdef ALU_PACKER_DROP_COUNT_EN
  logic       w_drop;
  logic [7:0] r_drop_count;

  assign w_drop = bus.ALU_result_valid && w_fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count <= 8'd0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule : alu_result_packer
